// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared encodings for the data memory responder.
package rv32_mem_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane steering for stores and load extraction/extension.
module mem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic        isUnsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byteEn,
  output logic [31:0] wordData,
  output logic [31:0] rdata,
  output logic        alignErr
);
  logic [4:0]  shift;
  logic [31:0] lane;
  assign shift    = {addrLo, 3'b000};
  assign alignErr = size == 2'b11 || (size == SIZE_H && addrLo[0]) || (size == SIZE_W && addrLo != 2'b00);
  assign byteEn   = size == SIZE_B ? 4'b0001 << addrLo : size == SIZE_H ? 4'b0011 << addrLo : 4'b1111;
  assign wordData = wdata << shift;
  assign lane     = rword >> shift;
  assign rdata    = size == SIZE_B ? {{24{~isUnsigned & lane[7]}}, lane[7:0]}
                  : size == SIZE_H ? {{16{~isUnsigned & lane[15]}}, lane[15:0]}
                  : rword;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding valid/ready data memory with fixed wait states.
module data_mem_responder
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_e            state, nextState;
  logic [WAIT_W-1:0] cnt;
  logic              writeQ, unsignedQ;
  logic [31:0]       addrQ, wdataQ;
  logic [1:0]        sizeQ;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              opWrite, opUnsigned;
  logic [31:0]       opAddr, opWdata;
  logic [1:0]        opSize;
  logic [AW-1:0]     idx;
  logic [3:0]        byteEn;
  logic [31:0]       wordData, loadData;
  logic              alignErr, err, accept, enterResp;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept    = req_valid && req_ready;
  // With zero wait states the response is formed on the accept edge, before the latches hold the request.
  assign opWrite    = state == IDLE ? req_write    : writeQ;
  assign opUnsigned = state == IDLE ? req_unsigned : unsignedQ;
  assign opAddr     = state == IDLE ? req_addr     : addrQ;
  assign opWdata    = state == IDLE ? req_wdata    : wdataQ;
  assign opSize     = state == IDLE ? req_size     : sizeQ;
  assign idx        = opAddr[AW+1:2];
  assign err        = alignErr || opAddr[31:2] >= 30'(DEPTH_WORDS);
  assign enterResp  = !resetn && state != RESP && nextState == RESP;
  mem_lane_align u_align (
    .size(opSize), .addrLo(opAddr[1:0]), .isUnsigned(opUnsigned), .wdata(opWdata),
    .rword(mem[idx]), .byteEn(byteEn), .wordData(wordData), .rdata(loadData), .alignErr(alignErr)
  );
  always_comb begin
    nextState = state;
    if (state == IDLE && accept) nextState = WAIT_CYCLES == 0 ? RESP : WAIT;
    if (state == WAIT && cnt == WAIT_W'(WAIT_CYCLES - 1)) nextState = RESP;
    if (state == RESP && rsp_ready) nextState = IDLE;
  end
  always_ff @(posedge clk) state <= resetn ? IDLE : nextState;
  always_ff @(posedge clk) begin
    if (resetn) begin
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        writeQ    <= req_write;
        unsignedQ <= req_unsigned;
        addrQ     <= req_addr;
        wdataQ    <= req_wdata;
        sizeQ     <= req_size;
      end
      cnt <= accept ? '0 : (state == WAIT && cnt != '1) ? cnt + 4'd1 : cnt;
      if (enterResp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || opWrite) ? '0 : loadData;
      end
    end
  end
  // Storage has no reset; stores commit only on the edge entering RESP.
  always_ff @(posedge clk)
    if (enterResp && opWrite && !err)
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) mem[idx][8*b +: 8] <= wordData[8*b +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed plus randomized checks against a byte-array memory model.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int WAITS = 2;
  logic clk = 1'b0, resetn = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = 2'b10;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  int total = 0, bad = 0;
  logic [7:0] refMem [256];
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] s, input bit u, output logic [31:0] rd, output bit e);
    int n = 1 << s;
    rd = '0;
    e = s == 2'b11 || (a % n) != 0 || (a >> 2) >= DEPTH;
    if (e) return;
    for (int i = 0; i < n; i++)
      if (w) refMem[a + i] = d[8*i +: 8];
      else rd |= 32'(refMem[a + i]) << (8 * i);
    if (!w && !u && rd[8*n-1]) rd |= ~32'h0 << (8 * n);
  endfunction
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit u, input int hold, output logic [31:0] rd, output logic e);
    logic [31:0] mrd;
    bit me;
    int lat;
    model(w, a, d, s, u, mrd, me);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = u;
    rsp_ready = hold == 0;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    check("latency", lat, WAITS + 1);
    rd = rsp_rdata;
    e = rsp_err;
    check("rdata", rd, mrd);
    check("err", e, me);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_valid", rsp_valid, 1);
        check("bp_rdata", rsp_rdata, rd);
        check("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_idle_ready", req_ready, 1);
      check("bp_valid_low", rsp_valid, 0);
    end
  endtask
  initial begin
    logic [31:0] rd, a;
    logic e;
    logic [1:0] s;
    repeat (2) @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_ready", req_ready, 1);
    resetn = 1'b0;
    for (int i = 0; i < 64; i++) xact(1, 32'(i * 4), $urandom, 2'b10, 0, 0, rd, e);
    xact(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, rd, e);
    xact(0, 32'h10, 0, 2'b10, 0, 0, rd, e);
    check("w10", rd, 32'hDEADBEEF);
    check("w10_err", e, 0);
    xact(0, 32'h13, 0, 2'b00, 0, 0, rd, e);
    check("b13_s", rd, 32'hFFFFFFDE);
    xact(0, 32'h13, 0, 2'b00, 1, 0, rd, e);
    check("b13_u", rd, 32'h000000DE);
    xact(0, 32'h10, 0, 2'b01, 0, 0, rd, e);
    check("h10_s", rd, 32'hFFFFBEEF);
    xact(1, 32'h11, 32'h55, 2'b00, 0, 0, rd, e);
    xact(0, 32'h10, 0, 2'b10, 0, 0, rd, e);
    check("w10_part", rd, 32'hDEAD55EF);
    xact(0, 32'h12, 0, 2'b10, 0, 0, rd, e);
    check("mis_w_err", e, 1);
    check("mis_w_rdata", rd, 0);
    xact(1, 32'h11, 32'hAAAA, 2'b01, 0, 0, rd, e);
    check("mis_h_err", e, 1);
    xact(0, 32'h10, 0, 2'b10, 0, 0, rd, e);
    check("mis_h_keep", rd, 32'hDEAD55EF);
    xact(0, 32'(4 * DEPTH), 0, 2'b10, 0, 0, rd, e);
    check("oor_err", e, 1);
    xact(0, 32'h10, 0, 2'b10, 0, 5, rd, e);
    check("bp_data", rd, 32'hDEAD55EF);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    check("rstw_valid", rsp_valid, 0);
    check("rstw_ready", req_ready, 1);
    xact(0, 32'h20, 0, 2'b10, 0, 0, rd, e);
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + $urandom_range(0, 255) : 32'($urandom_range(0, 255));
      s = 2'($urandom_range(0, 3));
      xact(1'($urandom), a, $urandom, s, 1'($urandom), ($urandom_range(0, 7) == 0) ? 2 : 0, rd, e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states between request accept and response (range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: synchronous, active-high reset (1 = reset).
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend a load, 0 = sign-extend.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the initiator takes the response.
REQ-014 The block SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and for errors.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: the access was misaligned, out of range, or used an illegal size.

Function
REQ-016 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; the block SHALL then latch write, addr, wdata, size and unsigned.
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP.
- req_ready is 1 only in IDLE.
- IDLE goes to WAIT on accept, or directly to RESP when WAIT_CYCLES = 0.
- WAIT goes to RESP when the wait counter reaches WAIT_CYCLES-1.
- RESP goes to IDLE when rsp_ready = 1.
REQ-018 rsp_valid SHALL be 1 exactly while in RESP; rsp_rdata and rsp_err SHALL hold stable until the response is taken.
REQ-019 Latency SHALL be WAIT_CYCLES+1 cycles from the accept edge to rsp_valid = 1; only one transaction is outstanding at a time.
REQ-020 An error SHALL be flagged, with no storage change and rsp_rdata = 0, when any of these holds:
- size = 11;
- half access with addr[0] = 1;
- word access with addr[1:0] != 00;
- addr[31:2] >= DEPTH_WORDS.
REQ-021 Stores SHALL be little-endian; the byte enables are derived from size and addr[1:0]; only the enabled bytes are written.
REQ-022 A store SHALL commit on the same edge as the transition into RESP, never earlier.
REQ-023 Loads SHALL read the addressed lane(s), shift them to bit 0, and sign- or zero-extend them per req_unsigned.
REQ-024 When rsp_ready = 0 in RESP, the block SHALL stall indefinitely with no new accept (backpressure).
REQ-025 The wait counter SHALL be 4 bits and cleared on accept; it SHALL NOT wrap during a transaction.
REQ-026 A rsp_ready pulse outside RESP SHALL be ignored.

Reset
REQ-027 When resetn = 1 at a clock edge, the block SHALL set state to IDLE, clear the counter, set req_ready to 1 after reset, and set rsp_valid, rsp_err and rsp_rdata to 0.
REQ-028 Reset during WAIT SHALL abort the transaction without committing a store; reset during RESP SHALL drop the response.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package rv32_mem_pkg SHALL hold:
- the size encoding enum (SIZE_B, SIZE_H, SIZE_W);
- the FSM state enum;
- the WAIT_CYCLES width constant.
REQ-031 Lane steering and extension SHALL be one combinational sub-module, mem_lane_align, used for both store byte enables and load extraction; the FSM and storage stay in data_mem_responder.

Verification
REQ-032 The bench SHALL cover a store then load of a word: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid exactly 3 cycles after each accept.
REQ-033 The bench SHALL cover byte and half extension: after REQ-032, load byte at 0x13 signed -> 0xFFFFFFDE; load byte at 0x13 unsigned -> 0x000000DE; load half at 0x10 signed -> 0xFFFFBEEF.
REQ-034 The bench SHALL cover a partial store: store byte 0x55 at 0x11, then load word at 0x10 -> 0xDEAD55EF.
REQ-035 The bench SHALL cover error cases: load word at 0x12 -> rsp_err = 1, rsp_rdata = 0; store half at 0x11 -> rsp_err = 1 and a word load at 0x10 is unchanged; address 4*DEPTH_WORDS -> rsp_err = 1.
REQ-036 The bench SHALL cover backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable and req_ready = 0; then rsp_ready = 1 -> IDLE next cycle.
REQ-037 The bench SHALL cover reset mid-store: assert resetn in WAIT of a store word 0x12345678 to 0x20 -> a later load at 0x20 returns the prior value and rsp_valid = 0 after reset.
